// File: rtl/sdma_pkg.sv
// Shared definitions for the sample/measurement path.
//   ADC_W          : ADC sample width
//   ADC_FULL_SCALE : largest ADC code
//   pt_state_t     : peak tracker FSM states
package sdma_pkg;

    localparam int ADC_W          = 12;
    localparam int ADC_FULL_SCALE = 4095;

    typedef enum logic [1:0] {
        PT_IDLE  = 2'd0,
        PT_ARM   = 2'd1,
        PT_TRACK = 2'd2
    } pt_state_t;

endpackage

// File: rtl/edge_sync.sv
// Optional synchronizer chain followed by a registered rising-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : level input (asynchronous when STAGES >= 2)
//   rise       : one-clk pulse per rising edge of d
// STAGES = number of synchronizer flops. STAGES = 0 is for inputs already in
// the clk domain; they still get one input register so the detector never
// looks at a combinational path from outside the block. Latency from d to
// rise is max(STAGES,1) + 1 clocks.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    localparam int N = (STAGES < 1) ? 1 : STAGES;

    logic [N-1:0] sync_q;
    logic         last_q;
    logic         rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < N; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            last_q <= sync_q[N-1];
            rise_q <= sync_q[N-1] & ~last_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/adc_peak_tracker.sv
// Per-period amplitude tracker: max, min, peak-to-peak and sample count of
// each period of the comparator square wave, measured on the ADC samples.
//   clk, rst_n   : main clock, asynchronous active-low reset
//   en           : tracker enable (level)
//   adc_clk      : divided ADC clock (clk domain); rising edge = new sample
//   adc_data     : ADC sample, stable around adc_clk rising edge
//   signal_in    : asynchronous comparator square wave
//   vmax, vmin   : max / min of the last published window
//   vpp          : vmax - vmin
//   samples      : sample count of the last published window
//   valid        : one-clk publish pulse
//   clip         : last window contained a clipped sample
//   timeout      : last window was closed by the sample-count limit
//   dbg_state_o  : current FSM state (pt_state_t encoding)
// Result interface: valid is a one-cycle strobe with no back-pressure; the
// result outputs change only in the cycle valid is high and hold otherwise.
module adc_peak_tracker
    import sdma_pkg::*;
#(
    parameter int DATA_W      = ADC_W,
    parameter int CNT_W       = 16,
    parameter int MAX_SAMPLES = 65535,
    parameter int CLIP_HI     = 4090,
    parameter int CLIP_LO     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              adc_clk,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              signal_in,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vpp,
    output logic [CNT_W-1:0]  samples,
    output logic              valid,
    output logic              clip,
    output logic              timeout,
    output logic [1:0]        dbg_state_o
);

    localparam logic [DATA_W-1:0] CLIP_HI_V = DATA_W'(CLIP_HI);
    localparam logic [DATA_W-1:0] CLIP_LO_V = DATA_W'(CLIP_LO);
    localparam logic [CNT_W-1:0]  MAX_V     = CNT_W'(MAX_SAMPLES);

    // ------------------------------------------------------------------
    // Edge detection: signal_in -> sig_rise 3 clk, adc_clk -> smp_stb 2 clk
    // ------------------------------------------------------------------
    logic sig_rise;
    logic smp_stb;

    edge_sync #(.STAGES(2)) u_sig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (signal_in),
        .rise  (sig_rise)
    );

    edge_sync #(.STAGES(0)) u_smp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_clk),
        .rise  (smp_stb)
    );

    // Sample captured on smp_stb; stb_q marks it usable one clk later.
    // stb_q then lines up with sig_rise when both pins rise together,
    // which is exactly the "same clock" case handled below.
    logic [DATA_W-1:0] sample_q;
    logic              stb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            stb_q    <= 1'b0;
        end else begin
            stb_q <= smp_stb;
            if (smp_stb) begin
                sample_q <= adc_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Window accumulators and merge with the in-flight sample
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] cur_max_q, cur_min_q;
    logic [CNT_W-1:0]  cur_cnt_q;
    logic              cur_clip_q;

    logic              smp_gt, smp_lt, smp_clip;
    logic [DATA_W-1:0] mrg_max, mrg_min, vpp_d;
    logic [CNT_W-1:0]  mrg_cnt;
    logic              mrg_clip;

    assign smp_gt   = stb_q && (sample_q > cur_max_q);
    assign smp_lt   = stb_q && (sample_q < cur_min_q);
    assign smp_clip = stb_q && ((sample_q >= CLIP_HI_V) || (sample_q <= CLIP_LO_V));
    assign mrg_max  = smp_gt ? sample_q : cur_max_q;
    assign mrg_min  = smp_lt ? sample_q : cur_min_q;
    assign mrg_cnt  = cur_cnt_q + {{(CNT_W-1){1'b0}}, stb_q};
    assign mrg_clip = cur_clip_q | smp_clip;

    // Peak-to-peak from registered operands only: the three possible
    // differences are formed in parallel with the compares and selected by
    // them, so a sample arriving with the closing edge still costs one
    // subtract per stage. Both compares true only happens on an empty
    // window, where max = min = sample.
    always_comb begin
        vpp_d = '0;
        case ({smp_gt, smp_lt})
            2'b00:   vpp_d = cur_max_q - cur_min_q;
            2'b10:   vpp_d = sample_q - cur_min_q;
            2'b01:   vpp_d = cur_max_q - sample_q;
            default: vpp_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    pt_state_t state_q, state_d;
    logic      acc_clear, acc_update, publish, pub_timeout;

    always_comb begin
        state_d     = state_q;
        acc_clear   = 1'b0;
        acc_update  = 1'b0;
        publish     = 1'b0;
        pub_timeout = 1'b0;
        if (!en) begin
            state_d   = PT_IDLE;
            acc_clear = 1'b1;
        end else begin
            case (state_q)
                PT_IDLE: begin
                    state_d   = PT_ARM;
                    acc_clear = 1'b1;
                end
                PT_ARM: begin
                    acc_clear = 1'b1;
                    if (sig_rise) begin
                        state_d = PT_TRACK;
                    end
                end
                PT_TRACK: begin
                    // The edge wins over a simultaneous count limit.
                    if (sig_rise) begin
                        acc_clear = 1'b1;
                        publish   = (mrg_cnt != '0);
                    end else if (stb_q) begin
                        if (mrg_cnt == MAX_V) begin
                            acc_clear   = 1'b1;
                            publish     = 1'b1;
                            pub_timeout = 1'b1;
                        end else begin
                            acc_update = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = PT_IDLE;
                    acc_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_max_q  <= '0;
            cur_min_q  <= '1;
            cur_cnt_q  <= '0;
            cur_clip_q <= 1'b0;
        end else if (acc_clear) begin
            cur_max_q  <= '0;
            cur_min_q  <= '1;
            cur_cnt_q  <= '0;
            cur_clip_q <= 1'b0;
        end else if (acc_update) begin
            cur_max_q  <= mrg_max;
            cur_min_q  <= mrg_min;
            cur_cnt_q  <= mrg_cnt;
            cur_clip_q <= mrg_clip;
        end
    end

    // ------------------------------------------------------------------
    // Published results
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] vmax_q, vmin_q, vpp_q;
    logic [CNT_W-1:0]  samples_q;
    logic              valid_q, clip_q, timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vmax_q    <= '0;
            vmin_q    <= '0;
            vpp_q     <= '0;
            samples_q <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= publish;
            if (publish) begin
                vmax_q    <= mrg_max;
                vmin_q    <= mrg_min;
                vpp_q     <= vpp_d;
                samples_q <= mrg_cnt;
                clip_q    <= mrg_clip;
                timeout_q <= pub_timeout;
            end
        end
    end

    assign vmax        = vmax_q;
    assign vmin        = vmin_q;
    assign vpp         = vpp_q;
    assign samples     = samples_q;
    assign valid       = valid_q;
    assign clip        = clip_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_peak_tracker.sv
module tb_adc_peak_tracker;
    import sdma_pkg::*;

    localparam int MAXS = 300;
    localparam int EW   = 12 * 3 + 16 + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        adc_clk;
    logic [11:0] adc_data;
    logic        signal_in;
    logic [11:0] vmax, vmin, vpp;
    logic [15:0] samples;
    logic        valid, clip, timeout;
    logic [1:0]  dbg_state_o;

    adc_peak_tracker #(
        .MAX_SAMPLES (MAXS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .adc_clk     (adc_clk),
        .adc_data    (adc_data),
        .signal_in   (signal_in),
        .vmax        (vmax),
        .vmin        (vmin),
        .vpp         (vpp),
        .samples     (samples),
        .valid       (valid),
        .clip        (clip),
        .timeout     (timeout),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int errors   = 0;
    int n_valid  = 0;
    int n_pushed = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int mx, input int mn, input int pp, input int cnt,
                            input bit cl, input bit to);
        exp_q.push_back({12'(mx), 12'(mn), 12'(pp), 16'(cnt), cl, to});
        n_pushed++;
    endtask

    always @(posedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (rst_n && valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid with vmax=%0d samples=%0d, expected no publish (t=%0t)",
                         vmax, samples, $time);
            end else begin
                e = exp_q.pop_front();
                check("vmax",    vmax,    e[53:42]);
                check("vmin",    vmin,    e[41:30]);
                check("vpp",     vpp,     e[29:18]);
                check("samples", samples, e[17:2]);
                check("clip",    clip,    e[1]);
                check("timeout", timeout, e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One ADC sample period = 4 clk; optional signal_in rise on the same clk.
    task automatic step_sample(input int x, input bit rise);
        adc_clk  = 1'b1;
        adc_data = 12'(x);
        if (rise) signal_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        adc_clk   = 1'b0;
        signal_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic sig_pulse_only();
        signal_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        signal_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input int mx, input int mn, input int pp,
                                 input int cnt, input bit cl, input bit to);
        check({tag, "_vmax"},    vmax,    mx);
        check({tag, "_vmin"},    vmin,    mn);
        check({tag, "_vpp"},     vpp,     pp);
        check({tag, "_samples"}, samples, cnt);
        check({tag, "_clip"},    clip,    cl);
        check({tag, "_timeout"}, timeout, to);
        check({tag, "_valid"},   valid,   1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int lo;
        int hi;
        int n;
        int e_max;
        int e_min;
        int e_vpp;
        int e_cnt;
        bit e_clip;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int x;

        vecs[0] = '{100, 3000, 200, 3000, 100, 2900, 200, 1'b0};
        vecs[1] = '{100, 3000, 200, 3000, 100, 2900, 200, 1'b0};
        vecs[2] = '{100, 3000, 200, 3000, 100, 2900, 200, 1'b0};
        vecs[3] = '{4095, 4095, 10, 4095, 4095, 0, 10, 1'b1};
        vecs[4] = '{2048, 2048, 10, 2048, 2048, 0, 10, 1'b0};
        vecs[5] = '{3, 3, 6, 3, 3, 0, 6, 1'b1};
        vecs[6] = '{6, 4089, 5, 4089, 6, 4083, 5, 1'b0};
        vecs[7] = '{5, 5, 1, 5, 5, 0, 1, 1'b1};
        vecs[8] = '{4090, 4090, 2, 4090, 4090, 0, 2, 1'b1};
        vecs[9] = '{0, 4095, 8, 4095, 0, 4095, 8, 1'b1};

        // ---- reset ----
        rst_n     = 1'b0;
        en        = 1'b0;
        adc_clk   = 1'b0;
        adc_data  = '0;
        signal_in = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("rst", 0, 0, 0, 0, 1'b0, 1'b0);
        check("rst_state", dbg_state_o, PT_IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_state", dbg_state_o, PT_IDLE);

        // ---- enable, arm, table-driven windows ----
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("arm_state", dbg_state_o, PT_ARM);
        sig_pulse_only();
        repeat (4) @(negedge clk);
        check("track_state", dbg_state_o, PT_TRACK);
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                if (vecs[v].n == 1) x = vecs[v].lo;
                else x = vecs[v].lo + ((vecs[v].hi - vecs[v].lo) * i) / (vecs[v].n - 1);
                if (i == vecs[v].n - 1)
                    push_exp(vecs[v].e_max, vecs[v].e_min, vecs[v].e_vpp, vecs[v].e_cnt,
                             vecs[v].e_clip, 1'b0);
                step_sample(x, i == vecs[v].n - 1);
            end
        end

        // ---- sample and edge together: sample closes the old window ----
        step_sample(500, 1'b0);
        step_sample(2000, 1'b0);
        step_sample(1500, 1'b0);
        push_exp(3500, 500, 3000, 4, 1'b0, 1'b0);
        step_sample(3500, 1'b1);
        step_sample(800, 1'b0);
        step_sample(1000, 1'b0);
        step_sample(900, 1'b0);
        push_exp(1000, 700, 300, 4, 1'b0, 1'b0);
        step_sample(700, 1'b1);

        // ---- edges with no sample in between: no publish ----
        sig_pulse_only();
        sig_pulse_only();
        step_sample(1200, 1'b0);
        push_exp(1300, 1200, 100, 2, 1'b0, 1'b0);
        step_sample(1300, 1'b1);

        // ---- timeout windows (signal_in held low) ----
        for (int i = 0; i < MAXS; i++) begin
            if (i == MAXS - 1) push_exp(1600, 1000, 600, MAXS, 1'b0, 1'b1);
            step_sample(1000 + (i % 7) * 100, 1'b0);
        end
        for (int i = 0; i < MAXS; i++) begin
            if (i == MAXS - 1) push_exp(1300, 500, 800, MAXS, 1'b0, 1'b1);
            step_sample(500 + (i % 5) * 200, 1'b0);
        end
        // Edge on the sample that reaches the limit: edge wins.
        for (int i = 0; i < MAXS; i++) begin
            if (i == MAXS - 1) push_exp(2020, 2000, 20, MAXS, 1'b0, 1'b0);
            step_sample(2000 + (i % 3) * 10, i == MAXS - 1);
        end

        // ---- en=0 mid-window: discarded, outputs hold ----
        step_sample(2500, 1'b0);
        step_sample(2600, 1'b0);
        en = 1'b0;
        step_sample(4000, 1'b1);
        repeat (4) @(negedge clk);
        check_outputs("hold", 2020, 2000, 20, MAXS, 1'b0, 1'b0);
        check("disabled_state", dbg_state_o, PT_IDLE);
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("reenable_state", dbg_state_o, PT_ARM);
        sig_pulse_only();
        step_sample(3000, 1'b0);
        push_exp(3000, 100, 2900, 2, 1'b0, 1'b0);
        step_sample(100, 1'b1);

        // ---- asynchronous reset mid-window ----
        step_sample(700, 1'b0);
        step_sample(800, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 0, 0, 0, 0, 1'b0, 1'b0);
        check("async_rst_state", dbg_state_o, PT_IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step_sample(900, 1'b0);
        step_sample(950, 1'b1);
        check_outputs("post_rst", 0, 0, 0, 0, 1'b0, 1'b0);
        step_sample(1111, 1'b0);
        push_exp(2222, 1111, 1111, 2, 1'b0, 1'b0);
        step_sample(2222, 1'b1);

        // ---- drain and report ----
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        check("pending_expected", exp_q.size(), 0);
        check("valid_count", n_valid, n_pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_peak_tracker.md
# adc_peak_tracker

Per-period amplitude tracker on the ADC sample path: consumes the synchronized ADC samples and the comparator square wave, and measures max, min and peak-to-peak of each signal period. It sits downstream of the ADC interface, beside the dual buffer. Its results feed the wave-information register bank for MCU readout and give gain control a per-period amplitude. Everything runs in the `clk` domain; `adc_clk` is used only as a sample strobe source.

## Interface
- `DATA_W`, 12: ADC sample width.
- `CNT_W`, 16: width of the per-window sample counter.
- `MAX_SAMPLES`, 65535: timeout, in samples, for a window with no closing edge.
- `CLIP_HI`, 4090: sample ≥ this sets clip.
- `CLIP_LO`, 5: sample ≤ this sets clip.
- `clk`  in  1  main clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `en`  in  1  tracker enable, level.
- `adc_clk`  in  1  divided ADC clock, generated in `clk` domain; each rising edge marks a new sample.
- `adc_data`  in  DATA_W  synchronized ADC sample, stable around `adc_clk` rising edge.
- `signal_in`  in  1  comparator square wave, asynchronous.
- `vmax`  out  DATA_W  max of last published window.
- `vmin`  out  DATA_W  min of last published window.
- `vpp`  out  DATA_W  vmax − vmin.
- `samples`  out  CNT_W  sample count of last published window.
- `valid`  out  1  one-clk pulse when new results are published.
- `clip`  out  1  last window contained a clipped sample.
- `timeout`  out  1  last window was closed by timeout, not by an edge.

## Operation
- `signal_in`: 2-flop synchronizer, then rising-edge detect, giving `sig_rise`.
- `adc_clk`: registered, then rising-edge detect, giving `smp_stb`. Sample is `adc_data` registered on `smp_stb`.
- FSM states: IDLE, ARM, TRACK.
  - IDLE → ARM when `en`=1.
  - ARM → TRACK on `sig_rise`. Accumulators cleared: cur_max=0, cur_min=2^DATA_W−1, cnt=0, cur_clip=0.
  - TRACK, on `smp_stb`: update cur_max and cur_min with the sample, cnt+1, OR clip test into cur_clip.
  - TRACK, on `sig_rise` with cnt≥1: publish, clear accumulators, stay in TRACK.
  - TRACK, on `sig_rise` with cnt=0: no publish, stay in TRACK. This is a window faster than the sample rate.
  - TRACK, when cnt reaches MAX_SAMPLES: publish with timeout=1, clear accumulators, stay in TRACK.
  - Any state, `en`=0 → IDLE. Accumulators are cleared; published outputs hold their values.
- Publish: vmax←cur_max, vmin←cur_min, vpp←cur_max−cur_min (unsigned, never negative because cnt≥1), samples←cnt, clip←cur_clip, timeout as above, valid=1 for one clk.
- Simultaneous `smp_stb` and `sig_rise`: the sample belongs to the closing window. It is included in the published values, and the new window starts empty.
- Simultaneous timeout and `sig_rise`: edge wins, so timeout=0.
- cnt never wraps. Timeout fires at exactly MAX_SAMPLES.

## Timing
- Reset values: vmax=vmin=vpp=0, samples=0, valid=clip=timeout=0, FSM=IDLE.
- Asynchronous reset assertion mid-window: the window is discarded, with no valid pulse.
- `signal_in` rising → `sig_rise`: 3 clk.
- `sig_rise` → `valid` and updated outputs: 1 clk. Total from pin is 4 clk.
- `adc_clk` rise → `smp_stb`: 2 clk. The sample is captured in the same cycle as `smp_stb`, and the accumulator is updated 1 clk later.
- Outputs change only in the `valid` cycle. They are stable between pulses.
- `en` rising → first publish no earlier than the second `sig_rise`.
- Fmax target matches the rest of the design: one compare or subtract per stage, with vpp registered from the already-registered cur_max and cur_min.

## Structure
- Shared package `sdma_pkg` holds:
  - `ADC_W`=12;
  - `ADC_FULL_SCALE`=4095;
  - `typedef enum logic [1:0] {PT_IDLE, PT_ARM, PT_TRACK} pt_state_t`.
- One sub-module `edge_sync`:
  - parameter `STAGES`;
  - ports `clk`, `rst_n`, `d`, `rise`;
  - instantiated with STAGES=2 for `signal_in` and STAGES=0 for `adc_clk`.

## Test plan
- en=1, adc_clk=clk/4, ramp 100→3000 repeating every 200 samples, signal_in rising every 200 samples → each valid: vmax=3000, vmin=100, vpp=2900, samples=200, clip=0, timeout=0.
- Constant sample 4095 within one period → clip=1, vpp=0. The next window at 2048 → clip=0.
- signal_in held low after ARM, with a 1000-clk edge feeding samples → valid every 65535 samples with timeout=1, samples=65535.
- smp_stb and sig_rise in the same clk, with sample=3500 and prior max=2000 → published vmax=3500. The next window's max excludes 3500.
- Two signal_in edges with no sample between them → no valid pulse. en=0 mid-window → no publish, outputs hold; re-enable → ARM.
- rst_n pulsed low mid-TRACK, asynchronous to clk → all outputs 0 immediately, FSM=IDLE, no spurious valid after release.
